// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: priority-mode selectors,
// the access-size field type used on client and memory ports, and the
// transaction FSM state encoding.
package mem_port_arbiter_pkg;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  typedef logic [1:0] mem_acc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_picker.sv
// arb_rot_picker: combinational rotating priority picker.
// Ports:
//   req  - request vector, one bit per client
//   base - index where the priority search starts (wraps modulo N)
//   gnt  - one-hot winner, or zero when no request is set
module arb_rot_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  output logic [N-1:0]     gnt
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IDX_W'((32'(base) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: N-client arbiter in front of a single SDRAM/SD memory port.
// One client owns the port per transaction (IDLE -> BUSY -> RELEASE); its
// request fields are registered onto the memory port, per-beat acks and read
// data are routed back to it with zero latency.
// Ports:
//   clk, res             - clock, asynchronous active-high reset
//   cl_addr/cs/wr/acc/burst/din - flattened client request fields, client i at slice i
//   cl_dout, cl_ack      - shared read data, per-client one-hot beat ack
//   mem_addr/cs/wr/acc/burst/din - downstream request (din is a live mux of owner)
//   mem_dout, mem_ack    - downstream read data and per-beat ack
//   grant                - one-hot current owner
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS  = 4,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BURST_W      = 9,
  parameter int unsigned PRIO_MODE    = PRIO_FIXED,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]  cl_addr,
  input  logic [NUM_CLIENTS-1:0]         cl_cs,
  input  logic [NUM_CLIENTS-1:0]         cl_wr,
  input  logic [NUM_CLIENTS*2-1:0]       cl_acc,
  input  logic [NUM_CLIENTS*BURST_W-1:0] cl_burst,
  input  logic [NUM_CLIENTS*DATA_W-1:0]  cl_din,
  output logic [DATA_W-1:0]              cl_dout,
  output logic [NUM_CLIENTS-1:0]         cl_ack,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_cs,
  output logic                           mem_wr,
  output logic [1:0]                     mem_acc,
  output logic [BURST_W-1:0]             mem_burst,
  output logic [DATA_W-1:0]              mem_din,
  input  logic [DATA_W-1:0]              mem_dout,
  input  logic                           mem_ack,
  output logic [NUM_CLIENTS-1:0]         grant
);

  localparam int unsigned IDX_W    = $clog2(NUM_CLIENTS);
  localparam int unsigned WAIT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam bit          AGING_EN = (PRIO_MODE == PRIO_FIXED) && (STARVE_LIMIT != 0);

  arb_state_e           state_q, state_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic                 mem_cs_q, mem_cs_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  mem_acc_t             mem_acc_q, mem_acc_d;
  logic [BURST_W-1:0]   mem_burst_q, mem_burst_d;
  logic [BURST_W-1:0]   beat_q, beat_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WAIT_W-1:0]    wait_q [NUM_CLIENTS];
  logic [WAIT_W-1:0]    wait_d [NUM_CLIENTS];

  logic [NUM_CLIENTS-1:0] starved, norm_gnt, starve_gnt, win_gnt;
  logic [IDX_W-1:0]       norm_base, win_idx;

  // Starved requesters are searched first; otherwise the normal search runs
  // from 0 (fixed) or from the round-robin pointer.
  always_comb begin
    starved = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      starved[i] = AGING_EN && cl_cs[i] && (32'(wait_q[i]) >= STARVE_LIMIT);
    end
  end

  assign norm_base = (PRIO_MODE == PRIO_RR) ? rr_ptr_q : '0;

  arb_rot_picker #(.N(NUM_CLIENTS), .IDX_W(IDX_W)) u_norm_pick (
    .req  (cl_cs),
    .base (norm_base),
    .gnt  (norm_gnt)
  );

  arb_rot_picker #(.N(NUM_CLIENTS), .IDX_W(IDX_W)) u_starve_pick (
    .req  (starved),
    .base ('0),
    .gnt  (starve_gnt)
  );

  assign win_gnt = (|starved) ? starve_gnt : norm_gnt;

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (win_gnt[i]) win_idx = IDX_W'(i);
    end
  end

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and registered request path
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_cs_d    = mem_cs_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_acc_d   = mem_acc_q;
    mem_burst_d = mem_burst_q;
    beat_d      = beat_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|cl_cs) begin
          state_d     = ST_BUSY;
          grant_d     = win_gnt;
          mem_cs_d    = 1'b1;
          mem_wr_d    = cl_wr[win_idx];
          mem_addr_d  = cl_addr[32'(win_idx)*ADDR_W +: ADDR_W];
          mem_acc_d   = cl_acc[32'(win_idx)*2 +: 2];
          mem_burst_d = cl_burst[32'(win_idx)*BURST_W +: BURST_W];
          beat_d      = cl_burst[32'(win_idx)*BURST_W +: BURST_W];
          rr_ptr_d    = (32'(win_idx) == NUM_CLIENTS - 1) ? '0 : win_idx + 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          if (beat_q == '0) begin
            state_d  = ST_RELEASE;
            mem_cs_d = 1'b0;
            grant_d  = '0;
          end else begin
            beat_d = beat_q - 1'b1;
          end
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Aging: count cycles spent requesting without owning the port.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      wait_d[i] = wait_q[i];
      if (!cl_cs[i] || (state_q == ST_IDLE && win_gnt[i])) begin
        wait_d[i] = '0;
      end else if (!grant_q[i] && wait_q[i] != '1) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      grant_q     <= '0;
      mem_cs_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_acc_q   <= '0;
      mem_burst_q <= '0;
      beat_q      <= '0;
      rr_ptr_q    <= '0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) wait_q[i] <= '0;
    end else begin
      grant_q     <= grant_d;
      mem_cs_q    <= mem_cs_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_acc_q   <= mem_acc_d;
      mem_burst_q <= mem_burst_d;
      beat_q      <= beat_d;
      rr_ptr_q    <= rr_ptr_d;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) wait_q[i] <= wait_d[i];
    end
  end

  // Outputs: ack/data demux is gated by BUSY so stray acks are dropped.
  always_comb begin
    mem_din = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_q[i]) mem_din = cl_din[i*DATA_W +: DATA_W];
    end
    cl_ack  = (state_q == ST_BUSY && mem_ack) ? grant_q  : '0;
    cl_dout = (state_q == ST_BUSY && mem_ack) ? mem_dout : '0;
  end

  assign grant     = grant_q;
  assign mem_cs    = mem_cs_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_acc   = mem_acc_q;
  assign mem_burst = mem_burst_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance 0 is fixed priority with STARVE_LIMIT=8,
// instance 1 is round-robin. Memory acks every cycle while mem_cs is high.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]                res, ack_en, ack_force;
  logic [1:0][N*AW-1:0]      cl_addr;
  logic [1:0][N-1:0]         cl_cs, cl_wr;
  logic [1:0][2*N-1:0]       cl_acc;
  logic [1:0][N*BW-1:0]      cl_burst;
  logic [1:0][N*DW-1:0]      cl_din;
  logic [1:0][DW-1:0]        mem_dout;
  wire  [1:0][DW-1:0]        cl_dout, mem_din;
  wire  [1:0][N-1:0]         cl_ack, grant;
  wire  [1:0][AW-1:0]        mem_addr;
  wire  [1:0]                mem_cs, mem_wr, mem_ack;
  wire  [1:0][1:0]           mem_acc;
  wire  [1:0][BW-1:0]        mem_burst;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .NUM_CLIENTS (N),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .BURST_W     (BW),
      .PRIO_MODE   (g),
      .STARVE_LIMIT(8)
    ) u_dut (
      .clk       (clk),
      .res       (res[g]),
      .cl_addr   (cl_addr[g]),
      .cl_cs     (cl_cs[g]),
      .cl_wr     (cl_wr[g]),
      .cl_acc    (cl_acc[g]),
      .cl_burst  (cl_burst[g]),
      .cl_din    (cl_din[g]),
      .cl_dout   (cl_dout[g]),
      .cl_ack    (cl_ack[g]),
      .mem_addr  (mem_addr[g]),
      .mem_cs    (mem_cs[g]),
      .mem_wr    (mem_wr[g]),
      .mem_acc   (mem_acc[g]),
      .mem_burst (mem_burst[g]),
      .mem_din   (mem_din[g]),
      .mem_dout  (mem_dout[g]),
      .mem_ack   (mem_ack[g]),
      .grant     (grant[g])
    );
    assign mem_ack[g] = ack_force[g] | (ack_en[g] & mem_cs[g]);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int g, input int c, input logic wr, input int burst,
                     input logic [1:0] acc, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    cl_addr[g][c*AW +: AW]  = addr;
    cl_wr[g][c]             = wr;
    cl_burst[g][c*BW +: BW] = BW'(burst);
    cl_acc[g][c*2 +: 2]     = acc;
    cl_din[g][c*DW +: DW]   = din;
    cl_cs[g][c]             = 1'b1;
  endtask

  logic [N-1:0] seq [8];
  int           seq_cyc [8];
  int           n, cyc;
  logic [N-1:0] prev;

  initial begin
    res = '1; ack_en = '1; ack_force = '0;
    cl_addr = '0; cl_cs = '0; cl_wr = '0; cl_acc = '0; cl_burst = '0; cl_din = '0;
    mem_dout = '0;
    repeat (2) @(negedge clk);

    // Reset values
    for (int g = 0; g < 2; g++) begin
      chk("rst_grant", 32'(grant[g]), 0);
      chk("rst_cs", 32'(mem_cs[g]), 0);
      chk("rst_ack", 32'(cl_ack[g]), 0);
      chk("rst_addr", 32'(mem_addr[g]), 0);
      chk("rst_burst", 32'(mem_burst[g]), 0);
      chk("rst_dout", 32'(cl_dout[g]), 0);
    end
    res = '0;

    // T1: single client 2 read, burst=3
    @(negedge clk);
    req(0, 2, 1'b0, 3, 2'b01, 16'h1234, 16'h0);
    mem_dout[0] = 16'hA000;
    #1 chk("t1_no_comb_cs", 32'(mem_cs[0]), 0);
    @(negedge clk);
    chk("t1_cs", 32'(mem_cs[0]), 1);
    chk("t1_grant", 32'(grant[0]), 32'b0100);
    chk("t1_addr", 32'(mem_addr[0]), 32'h1234);
    chk("t1_burst", 32'(mem_burst[0]), 3);
    chk("t1_wr", 32'(mem_wr[0]), 0);
    chk("t1_acc", 32'(mem_acc[0]), 1);
    cl_cs[0][2] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("t1_ack", 32'(cl_ack[0]), 32'b0100);
      chk("t1_dout", 32'(cl_dout[0]), 32'hA000 + 32'(b));
      mem_dout[0] = DW'(16'hA000 + b + 1);
      @(negedge clk);
    end
    chk("t1_rel_cs", 32'(mem_cs[0]), 0);
    chk("t1_rel_grant", 32'(grant[0]), 0);
    chk("t1_rel_ack", 32'(cl_ack[0]), 0);
    // Stray ack in RELEASE and IDLE must not reach clients
    ack_force[0] = 1'b1;
    #1 chk("t1_stray_ack_rel", 32'(cl_ack[0]), 0);
    chk("t1_stray_dout_rel", 32'(cl_dout[0]), 0);
    @(negedge clk);
    chk("t1_stray_ack_idle", 32'(cl_ack[0]), 0);
    chk("t1_idle_cs", 32'(mem_cs[0]), 0);
    ack_force[0] = 1'b0;

    // T2: fixed, clients 0 and 3 simultaneous, burst=0
    @(negedge clk);
    req(0, 0, 1'b0, 0, 2'b10, 16'h0100, 16'h0);
    req(0, 3, 1'b0, 0, 2'b10, 16'h0300, 16'h0);
    @(negedge clk);
    chk("t2_grant0", 32'(grant[0]), 32'b0001);
    chk("t2_addr0", 32'(mem_addr[0]), 32'h0100);
    chk("t2_ack0", 32'(cl_ack[0]), 32'b0001);
    cl_cs[0][0] = 1'b0;
    @(negedge clk);
    chk("t2_rel_grant", 32'(grant[0]), 0);
    chk("t2_rel_cs", 32'(mem_cs[0]), 0);
    @(negedge clk);
    chk("t2_idle_grant", 32'(grant[0]), 0);
    @(negedge clk);
    chk("t2_grant3", 32'(grant[0]), 32'b1000);
    chk("t2_addr3", 32'(mem_addr[0]), 32'h0300);
    cl_cs[0][3] = 1'b0;
    @(negedge clk);
    chk("t2_rel3_grant", 32'(grant[0]), 0);
    @(negedge clk);

    // T3: aging; client 0 re-requests continuously, client 1 waits
    @(negedge clk);
    req(0, 0, 1'b0, 0, 2'b10, 16'h0010, 16'h0);
    req(0, 1, 1'b0, 0, 2'b10, 16'h0011, 16'h0);
    n = 0; prev = '0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (grant[0] != '0 && prev == '0) begin
        seq[n] = grant[0];
        n++;
      end
      prev = grant[0];
    end
    cl_cs[0] = '0;
    chk("t3_grant_count", 32'(n), 4);
    chk("t3_g0", 32'(seq[0]), 32'b0001);
    chk("t3_g1", 32'(seq[1]), 32'b0001);
    chk("t3_g2", 32'(seq[2]), 32'b0001);
    chk("t3_g3_starved", 32'(seq[3]), 32'b0010);
    repeat (3) @(negedge clk);
    chk("t3_idle_cs", 32'(mem_cs[0]), 0);

    // T5: owner drops cl_cs after 1st beat of burst=7 write
    @(negedge clk);
    req(0, 1, 1'b1, 7, 2'b10, 16'h0500, 16'hD000);
    @(negedge clk);
    chk("t5_grant", 32'(grant[0]), 32'b0010);
    chk("t5_wr", 32'(mem_wr[0]), 1);
    chk("t5_burst", 32'(mem_burst[0]), 7);
    cl_cs[0][1] = 1'b0;
    for (int b = 0; b < 8; b++) begin
      chk("t5_ack", 32'(cl_ack[0]), 32'b0010);
      chk("t5_din", 32'(mem_din[0]), 32'hD000 + 32'(b));
      cl_din[0][1*DW +: DW] = DW'(16'hD000 + b + 1);
      @(negedge clk);
    end
    chk("t5_rel_cs", 32'(mem_cs[0]), 0);
    chk("t5_rel_grant", 32'(grant[0]), 0);

    // T4: round-robin, all clients request continuously, burst=0
    @(negedge clk);
    for (int c = 0; c < N; c++) req(1, c, 1'b0, 0, 2'b10, AW'(16'h0200 + c), 16'h0);
    n = 0; prev = '0; cyc = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      cyc++;
      if (grant[1] != '0 && prev == '0) begin
        seq[n] = grant[1];
        seq_cyc[n] = cyc;
        n++;
      end
      prev = grant[1];
    end
    cl_cs[1] = '0;
    chk("t4_grant_count", 32'(n), 5);
    chk("t4_g0", 32'(seq[0]), 32'b0001);
    chk("t4_g1", 32'(seq[1]), 32'b0010);
    chk("t4_g2", 32'(seq[2]), 32'b0100);
    chk("t4_g3", 32'(seq[3]), 32'b1000);
    chk("t4_g4", 32'(seq[4]), 32'b0001);
    for (int i = 1; i < 5; i++) chk("t4_spacing", 32'(seq_cyc[i] - seq_cyc[i-1]), 3);
    repeat (4) @(negedge clk);

    // T6: reset during beat 2 of burst=5, then re-arbitration from pointer 0
    @(negedge clk);
    req(1, 2, 1'b0, 5, 2'b10, 16'h0700, 16'h0);
    @(negedge clk);
    chk("t6_grant", 32'(grant[1]), 32'b0100);
    @(negedge clk);
    @(negedge clk);
    chk("t6_beat2_ack", 32'(cl_ack[1]), 32'b0100);
    res[1] = 1'b1;
    req(1, 3, 1'b0, 0, 2'b10, 16'h0703, 16'h0);
    #1;
    chk("t6_rst_cs", 32'(mem_cs[1]), 0);
    chk("t6_rst_grant", 32'(grant[1]), 0);
    chk("t6_rst_ack", 32'(cl_ack[1]), 0);
    chk("t6_rst_addr", 32'(mem_addr[1]), 0);
    @(negedge clk);
    res[1] = 1'b0;
    @(negedge clk);
    chk("t6_rearb_grant", 32'(grant[1]), 32'b0100);
    chk("t6_rearb_addr", 32'(mem_addr[1]), 32'h0700);
    cl_cs[1] = '0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
